// File: rtl/touch_key_cond_if.sv
// Touch key conditioner signal bundle: raw sensor level in, debounced level and strobes out.
interface touch_key_cond_if;
  logic touch_key;
  logic key_level;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;

  modport master (
    output touch_key,
    input  key_level,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse
  );

  modport slave (
    input  touch_key,
    output key_level,
    output press_pulse,
    output release_pulse,
    output long_pulse
  );
endinterface

// File: rtl/touch_key_cond.sv
// Touch key conditioner: synchronizes the raw sensor, debounces press/release and
// flags a long hold.
//
// state        | meaning
// IDLE         | key released, waiting for key_s high
// PRESS_WAIT   | key_s high, counting the press debounce window
// PRESSED      | debounced press, hold timer running
// RELEASE_WAIT | key_s low while pressed, counting the release debounce window
module touch_key_cond #(
  parameter int DEB_CNT  = 50000,
  parameter int LONG_CNT = 50000000
) (
  input logic             clk,
  input logic             rst,
  touch_key_cond_if.slave key_if
);

  localparam int DW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam int HW = (LONG_CNT > 1) ? $clog2(LONG_CNT) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CNT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CNT - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t        state_q;
  logic          sync_q;
  logic          key_s_q;
  logic [DW-1:0] deb_cnt_q;
  logic [HW-1:0] hold_cnt_q;
  logic          long_done_q;
  logic          key_level_q;
  logic          press_q;
  logic          release_q;
  logic          long_q;
  logic          long_due;

  assign long_due = (hold_cnt_q == HOLD_LAST) && !long_done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sync_q      <= 1'b0;
      key_s_q     <= 1'b0;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      long_done_q <= 1'b0;
      key_level_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      sync_q    <= key_if.touch_key;
      key_s_q   <= sync_q;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;

      case (state_q)
        IDLE: begin
          if (key_s_q) begin
            state_q   <= PRESS_WAIT;
            deb_cnt_q <= '0;
          end
        end

        PRESS_WAIT: begin
          if (!key_s_q) begin
            state_q <= IDLE;
          end else if (deb_cnt_q == DEB_LAST) begin
            state_q     <= PRESSED;
            key_level_q <= 1'b1;
            press_q     <= 1'b1;
            hold_cnt_q  <= '0;
          end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
          end
        end

        PRESSED: begin
          if (hold_cnt_q != HOLD_LAST) hold_cnt_q <= hold_cnt_q + 1'b1;
          if (long_due) begin
            long_q      <= 1'b1;
            long_done_q <= 1'b1;
          end
          if (!key_s_q) begin
            state_q   <= RELEASE_WAIT;
            deb_cnt_q <= '0;
          end
        end

        RELEASE_WAIT: begin
          if (hold_cnt_q != HOLD_LAST) hold_cnt_q <= hold_cnt_q + 1'b1;
          if (long_due) begin
            long_q      <= 1'b1;
            long_done_q <= 1'b1;
          end
          // A due long strobe takes this cycle; the release follows one cycle later.
          if (key_s_q) begin
            state_q <= PRESSED;
          end else if (deb_cnt_q == DEB_LAST) begin
            if (!long_due) begin
              state_q     <= IDLE;
              key_level_q <= 1'b0;
              release_q   <= 1'b1;
              long_done_q <= 1'b0;
            end
          end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign key_if.key_level     = key_level_q;
  assign key_if.press_pulse   = press_q;
  assign key_if.release_pulse = release_q;
  assign key_if.long_pulse    = long_q;

endmodule
